regfile_mp_sb: RTL and testbench

- Parametrised successor to the 32x32 single-write/dual-read MIPS register file.
- Generalised in data width, register count and read-port count.
- Adds three things the current file lacks:
  - write-to-read bypass in the same cycle;
  - a per-register pending-write scoreboard for load-use and long-latency hazard detection;
  - a registered count of outstanding writes.
- Sits in the decode stage: hazard unit consumes rd_busy, WB stage drives the write port, issue logic drives the scoreboard set port.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_sb_ctr.sv | 72 +++++++
 rtl/regfile_mp_sb.sv | 80 ++++++++
 tb/tb_regfile_mp_sb.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and pipeline-facing types for the multi-port register file.
package regfile_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_NUM_RD   = 2;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

   // Types used by decode/issue/writeback stages when talking to the register file.
   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_ctr.sv
// Pending-write scoreboard: one busy bit per register, a running count of busy
// registers and a one-cycle flag for a second producer issued to a busy register.
module regfile_sb_ctr
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wrEn,
   input  logic [ADDR_W-1:0]   wrAddr,
   input  logic                setEn,
   input  logic [ADDR_W-1:0]   setAddr,
   output logic [NUM_REGS-1:0] sbVec,
   output logic [ADDR_W:0]     pendCnt,
   output logic                wawErr
);

   localparam bit ZERO_EN = (ZERO_REG != 0);

   logic                setValid;
   logic                clrValid;
   logic                sameAddr;
   logic                setBusy;
   logic                clrBusy;
   logic                incCnt;
   logic                decCnt;
   logic                wawNext;
   logic [NUM_REGS-1:0] sbNext;
   logic [ADDR_W:0]     cntNext;

   // Classify this cycle's set/clear pair and derive the count delta and WAW flag.
   always_comb begin
      setValid = setEn && !(ZERO_EN && (setAddr == '0));
      clrValid = wrEn && !(ZERO_EN && (wrAddr == '0));
      sameAddr = (setAddr == wrAddr);
      setBusy  = sbVec[setAddr];
      clrBusy  = sbVec[wrAddr];
      // A set only adds to the count if its target was idle; a clear only
      // subtracts if the target was busy and no new producer claims it.
      incCnt   = setValid && !setBusy;
      decCnt   = clrValid && clrBusy && !(setValid && sameAddr);
      wawNext  = setValid && setBusy && !(clrValid && sameAddr);
      cntNext  = pendCnt + {{ADDR_W{1'b0}}, incCnt} - {{ADDR_W{1'b0}}, decCnt};
   end

   // Per-register next busy bit: a set beats a same-cycle clear (new producer).
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gSbBit
      if (ZERO_EN && (gi == 0)) begin : gZero
         assign sbNext[gi] = 1'b0;
      end else begin : gNormal
         assign sbNext[gi] = (setValid && (setAddr == ADDR_W'(gi)))
                           | (sbVec[gi] && !(clrValid && (wrAddr == ADDR_W'(gi))));
      end
   end

   // Scoreboard, pending count and WAW pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sbVec   <= '0;
         pendCnt <= '0;
         wawErr  <= 1'b0;
      end else begin
         sbVec   <= sbNext;
         pendCnt <= cntNext;
         wawErr  <= wawNext;
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write-to-read bypass and a pending-write
// scoreboard feeding per-port busy flags to the hazard unit.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int NUM_REGS = DEF_NUM_REGS,
   parameter  int NUM_RD   = DEF_NUM_RD,
   parameter  int ZERO_REG = 1,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     sb_set_en,
   input  logic [ADDR_W-1:0]        sb_set_addr,
   output logic [ADDR_W:0]          pend_cnt,
   output logic                     waw_err
);

   localparam bit ZERO_EN = (ZERO_REG != 0);

   logic [DATA_W-1:0]   regArray [NUM_REGS];
   logic [NUM_REGS-1:0] sbVec;
   logic                wrWritable;

   // Writes to a hardwired-zero register are dropped so it can never hold data.
   assign wrWritable = wr_en && !(ZERO_EN && (wr_addr == '0));

   // Register storage; reset clears every entry so reads after reset are zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regArray[i] <= '0;
         end
      end else if (wrWritable) begin
         regArray[wr_addr] <= wr_data;
      end
   end

   // Read ports: zero register first, then same-cycle writeback bypass, then storage.
   for (genvar gi = 0; gi < NUM_RD; gi++) begin : gRead
      logic [ADDR_W-1:0] portAddr;
      logic              addrMatch;
      logic              zeroHit;

      assign portAddr  = rd_addr[gi*ADDR_W +: ADDR_W];
      assign addrMatch = wr_en && (wr_addr == portAddr);
      assign zeroHit   = ZERO_EN && (portAddr == '0);

      assign rd_data[gi*DATA_W +: DATA_W] = zeroHit                   ? {DATA_W{1'b0}} :
                                            (addrMatch && wrWritable) ? wr_data        :
                                                                        regArray[portAddr];

      // Data arriving this cycle is bypassed, so the consumer need not stall.
      assign rd_busy[gi] = sbVec[portAddr] && !addrMatch;
   end

   regfile_sb_ctr #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) uSbCtr (
      .clk     (clk),
      .reset   (reset),
      .wrEn    (wr_en),
      .wrAddr  (wr_addr),
      .setEn   (sb_set_en),
      .setAddr (sb_set_addr),
      .sbVec   (sbVec),
      .pendCnt (pend_cnt),
      .wawErr  (waw_err)
   );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a default 32x32/2-port instance and a 64x64/4-port
// instance share one stimulus stream and are compared against an array model.
module tb_regfile_mp_sb;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Shared stimulus (sized for the larger instance; the small one uses low bits)
   logic        wrEn;
   logic [5:0]  wrAddr;
   logic [63:0] wrData;
   logic        setEn;
   logic [5:0]  setAddr;
   logic [5:0]  rdAddr [4];

   // Instance A: defaults
   logic [9:0]  aRdAddr;
   logic [63:0] aRdData;
   logic [1:0]  aRdBusy;
   logic [5:0]  aPend;
   logic        aWaw;
   assign aRdAddr = {rdAddr[1][4:0], rdAddr[0][4:0]};

   regfile_mp_sb dutA (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wrEn),
      .wr_addr     (wrAddr[4:0]),
      .wr_data     (wrData[31:0]),
      .rd_addr     (aRdAddr),
      .rd_data     (aRdData),
      .rd_busy     (aRdBusy),
      .sb_set_en   (setEn),
      .sb_set_addr (setAddr[4:0]),
      .pend_cnt    (aPend),
      .waw_err     (aWaw)
   );

   // Instance B: 64-bit data, 64 registers, 4 read ports
   logic [23:0]  bRdAddr;
   logic [255:0] bRdData;
   logic [3:0]   bRdBusy;
   logic [6:0]   bPend;
   logic         bWaw;
   assign bRdAddr = {rdAddr[3], rdAddr[2], rdAddr[1], rdAddr[0]};

   regfile_mp_sb #(.DATA_W(64), .NUM_REGS(64), .NUM_RD(4), .ZERO_REG(1)) dutB (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wrEn),
      .wr_addr     (wrAddr),
      .wr_data     (wrData),
      .rd_addr     (bRdAddr),
      .rd_data     (bRdData),
      .rd_busy     (bRdBusy),
      .sb_set_en   (setEn),
      .sb_set_addr (setAddr),
      .pend_cnt    (bPend),
      .waw_err     (bWaw)
   );

   // Observed values gathered per instance/port
   logic [63:0] actRd   [2][4];
   logic        actBusy [2][4];
   logic [6:0]  actPend [2];
   logic        actWaw  [2];

   always_comb begin
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 4; k++) begin
            actRd[d][k]   = '0;
            actBusy[d][k] = 1'b0;
         end
      end
      actRd[0][0]   = {32'h0, aRdData[31:0]};
      actRd[0][1]   = {32'h0, aRdData[63:32]};
      actBusy[0][0] = aRdBusy[0];
      actBusy[0][1] = aRdBusy[1];
      for (int k = 0; k < 4; k++) begin
         actRd[1][k]   = bRdData[k*64 +: 64];
         actBusy[1][k] = bRdBusy[k];
      end
      actPend[0] = {1'b0, aPend};
      actPend[1] = bPend;
      actWaw[0]  = aWaw;
      actWaw[1]  = bWaw;
   end

   // Reference model: register contents, pending set, last WAW indication
   logic [63:0] mRegs [2][64];
   logic        mSb   [2][64];
   logic        mWaw  [2];

   int checks = 0;
   int passes = 0;

   function automatic int nRd(int d);
      return (d == 0) ? 2 : 4;
   endfunction

   function automatic logic [5:0] maskA(int d, logic [5:0] a);
      return (d == 0) ? {1'b0, a[4:0]} : a;
   endfunction

   function automatic logic [63:0] maskD(int d, logic [63:0] v);
      return (d == 0) ? {32'h0, v[31:0]} : v;
   endfunction

   function automatic logic [63:0] expRd(int d, int k);
      logic [5:0] a;
      a = maskA(d, rdAddr[k]);
      if (a == 6'd0) return 64'h0;
      if (wrEn && (maskA(d, wrAddr) == a)) return maskD(d, wrData);
      return mRegs[d][a];
   endfunction

   function automatic logic expBusy(int d, int k);
      logic [5:0] a;
      a = maskA(d, rdAddr[k]);
      return mSb[d][a] && !(wrEn && (maskA(d, wrAddr) == a));
   endfunction

   function automatic int expPend(int d);
      int n = 0;
      for (int i = 0; i < 64; i++) n += mSb[d][i] ? 1 : 0;
      return n;
   endfunction

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 64; i++) begin
            mRegs[d][i] = '0;
            mSb[d][i]   = 1'b0;
         end
         mWaw[d] = 1'b0;
      end
   endtask

   // Advance one clock and apply the same event to the model
   task automatic tick();
      logic [5:0] wa, sa;
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         wa = maskA(d, wrAddr);
         sa = maskA(d, setAddr);
         mWaw[d] = setEn && (sa != 0) && mSb[d][sa] && !(wrEn && (wa == sa));
         if (wrEn && (wa != 0)) begin
            mRegs[d][wa] = maskD(d, wrData);
            mSb[d][wa]   = 1'b0;
         end
         if (setEn && (sa != 0)) mSb[d][sa] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      wrEn = 1'b0; wrAddr = '0; wrData = '0;
      setEn = 1'b0; setAddr = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      for (int k = 0; k < 4; k++) rdAddr[k] = '0;
      modelReset();
      #12;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (actPend[d] !== 7'(expPend(d)) || actWaw[d] !== 1'b0)
            $display("FAIL reset_init dut%0d pend=%0d waw=%b want pend=%0d waw=0", d, actPend[d], actWaw[d], expPend(d));
         else passes++;
      end
      @(negedge clk);
      reset = 1'b1;
      // Make state non-trivial: reg5 written, reg3 busy, then a WAW on reg3
      setEn = 1'b1; setAddr = 6'd3; wrEn = 1'b1; wrAddr = 6'd5; wrData = 64'h1111;
      tick();
      wrEn = 1'b0;
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (actWaw[d] !== mWaw[d] || actPend[d] !== 7'(expPend(d)))
            $display("FAIL pre_reset dut%0d waw=%b pend=%0d want waw=%b pend=%0d", d, actWaw[d], actPend[d], mWaw[d], expPend(d));
         else passes++;
      end
      // Reset asserted mid-cycle with a write in flight
      setEn = 1'b0;
      wrEn = 1'b1; wrAddr = 6'd5; wrData = 64'hDEADBEEF;
      rdAddr[0] = 6'd5; rdAddr[1] = 6'd3;
      reset = 1'b0;
      modelReset();
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (actPend[d] !== 7'd0 || actWaw[d] !== 1'b0)
            $display("FAIL reset_async dut%0d pend=%0d waw=%b want pend=0 waw=0", d, actPend[d], actWaw[d]);
         else passes++;
      end
      @(posedge clk);
      #1;
      wrEn = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (actRd[d][0] !== expRd(d, 0) || actBusy[d][1] !== expBusy(d, 1))
            $display("FAIL reset_reg5 dut%0d rd=%h busy=%b want rd=%h busy=%b", d, actRd[d][0], actBusy[d][1], expRd(d, 0), expBusy(d, 1));
         else passes++;
      end
      reset = 1'b1;
   endtask

   task automatic test_bypass();
      idle();
      wrEn = 1'b1; wrAddr = 6'd7; wrData = 64'h12345678;
      for (int k = 0; k < 4; k++) rdAddr[k] = 6'd7;
      #1;
      for (int pass = 0; pass < 2; pass++) begin
         for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < nRd(d); k++) begin
               checks++;
               if (actRd[d][k] !== expRd(d, k) || actBusy[d][k] !== expBusy(d, k))
                  $display("FAIL bypass%0d dut%0d port%0d rd=%h busy=%b want rd=%h busy=%b", pass, d, k, actRd[d][k], actBusy[d][k], expRd(d, k), expBusy(d, k));
               else passes++;
            end
         end
         if (pass == 0) begin
            tick();
            wrEn = 1'b0;
            #1;
         end
      end
   endtask

   task automatic test_zero_reg();
      idle();
      wrEn = 1'b1; wrAddr = 6'd0; wrData = '1;
      setEn = 1'b1; setAddr = 6'd0;
      for (int k = 0; k < 4; k++) rdAddr[k] = 6'd0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (actRd[d][0] !== 64'h0 || actBusy[d][0] !== 1'b0)
            $display("FAIL zero_comb dut%0d rd=%h busy=%b want rd=0 busy=0", d, actRd[d][0], actBusy[d][0]);
         else passes++;
      end
      tick();
      idle();
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (actRd[d][0] !== expRd(d, 0) || actBusy[d][0] !== expBusy(d, 0) ||
             actPend[d] !== 7'(expPend(d)) || actWaw[d] !== mWaw[d])
            $display("FAIL zero_after dut%0d rd=%h busy=%b pend=%0d waw=%b want rd=%h busy=%b pend=%0d waw=%b", d,
                     actRd[d][0], actBusy[d][0], actPend[d], actWaw[d], expRd(d, 0), expBusy(d, 0), expPend(d), mWaw[d]);
         else passes++;
      end
   endtask

   task automatic test_load_use();
      idle();
      setEn = 1'b1; setAddr = 6'd3;
      tick();
      setEn = 1'b0;
      for (int k = 0; k < 4; k++) rdAddr[k] = 6'd3;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) begin
            wrEn = 1'b1; wrAddr = 6'd3; wrData = 64'hA5;
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (actBusy[d][0] !== expBusy(d, 0) || actRd[d][0] !== expRd(d, 0) || actPend[d] !== 7'(expPend(d)))
               $display("FAIL load_use_c%0d dut%0d busy=%b rd=%h pend=%0d want busy=%b rd=%h pend=%0d", c, d,
                        actBusy[d][0], actRd[d][0], actPend[d], expBusy(d, 0), expRd(d, 0), expPend(d));
            else passes++;
         end
         tick();
      end
      idle();
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (actPend[d] !== 7'd0 || actRd[d][0] !== expRd(d, 0))
            $display("FAIL load_use_done dut%0d pend=%0d rd=%h want pend=0 rd=%h", d, actPend[d], actRd[d][0], expRd(d, 0));
         else passes++;
      end
   endtask

   task automatic test_simultaneous();
      idle();
      for (int k = 0; k < 4; k++) rdAddr[k] = 6'd9;
      // step 0: make reg9 busy; 1: set+clear reg9; 2: set reg9 alone; 3: idle; 4: clear
      for (int s = 0; s < 5; s++) begin
         idle();
         case (s)
            0, 2: begin setEn = 1'b1; setAddr = 6'd9; end
            1: begin setEn = 1'b1; setAddr = 6'd9; wrEn = 1'b1; wrAddr = 6'd9; wrData = 64'h99; end
            4: begin wrEn = 1'b1; wrAddr = 6'd9; wrData = 64'h9A; end
            default: ;
         endcase
         tick();
         idle();
         #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (actWaw[d] !== mWaw[d] || actPend[d] !== 7'(expPend(d)) || actBusy[d][0] !== expBusy(d, 0))
               $display("FAIL simul_s%0d dut%0d waw=%b pend=%0d busy=%b want waw=%b pend=%0d busy=%b", s, d,
                        actWaw[d], actPend[d], actBusy[d][0], mWaw[d], expPend(d), expBusy(d, 0));
            else passes++;
         end
      end
   endtask

   task automatic test_fill();
      idle();
      for (int a = 1; a < 64; a++) begin
         setEn = 1'b1; setAddr = 6'(a);
         tick();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (actPend[d] !== 7'(expPend(d)) || actWaw[d] !== mWaw[d])
               $display("FAIL fill_set a=%0d dut%0d pend=%0d waw=%b want pend=%0d waw=%b", a, d, actPend[d], actWaw[d], expPend(d), mWaw[d]);
            else passes++;
         end
      end
      checks++;
      if (actPend[0] !== 7'd31 || actPend[1] !== 7'd63)
         $display("FAIL fill_full pendA=%0d pendB=%0d want 31 and 63", actPend[0], actPend[1]);
      else passes++;
      setEn = 1'b0;
      for (int a = 1; a < 64; a++) begin
         wrEn = 1'b1; wrAddr = 6'(a); wrData = {$urandom, $urandom};
         tick();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (actPend[d] !== 7'(expPend(d)))
               $display("FAIL fill_clr a=%0d dut%0d pend=%0d want %0d", a, d, actPend[d], expPend(d));
            else passes++;
         end
      end
      idle();
      checks++;
      if (actPend[0] !== 7'd0 || actPend[1] !== 7'd0)
         $display("FAIL fill_empty pendA=%0d pendB=%0d want 0 and 0", actPend[0], actPend[1]);
      else passes++;
   endtask

   task automatic test_random();
      for (int it = 0; it < 400; it++) begin
         wrEn    = $urandom_range(0, 1) == 1;
         wrAddr  = 6'($urandom);
         wrData  = {$urandom, $urandom};
         setEn   = $urandom_range(0, 2) != 0;
         setAddr = ($urandom_range(0, 3) == 0) ? wrAddr : 6'($urandom);
         for (int k = 0; k < 4; k++)
            rdAddr[k] = ($urandom_range(0, 2) == 0) ? wrAddr : 6'($urandom);
         #1;
         for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < nRd(d); k++) begin
               checks++;
               if (actRd[d][k] !== expRd(d, k) || actBusy[d][k] !== expBusy(d, k))
                  $display("FAIL rand_read it=%0d dut%0d port%0d rd=%h busy=%b want rd=%h busy=%b", it, d, k,
                           actRd[d][k], actBusy[d][k], expRd(d, k), expBusy(d, k));
               else passes++;
            end
         end
         tick();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (actPend[d] !== 7'(expPend(d)) || actWaw[d] !== mWaw[d])
               $display("FAIL rand_state it=%0d dut%0d pend=%0d waw=%b want pend=%0d waw=%b", it, d,
                        actPend[d], actWaw[d], expPend(d), mWaw[d]);
            else passes++;
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_zero_reg();
      test_load_use();
      test_simultaneous();
      test_fill();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
